div_seq_ctrl: RTL

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: programmable tick divider with run / single-step / pause sequencing.
// Ports: clk, rst (asynchronous, active-low);
//   cfg_valid/cfg_ready/cfg_div/cfg_limit  configuration handshake (accepted in IDLE or PAUSE);
//   cmd_start/cmd_stop/cmd_step            sequencing commands (stop > step > start);
//   tick/div_clk/tick_count/busy/done/state status outputs.
// Optional feature: define DIVCTRL_PRESCALE_EN to advance the divider once per 10 clk.
module div_seq_ctrl #(
  parameter int DIV_W = 12,
  parameter int CNT_W = 8,
  parameter int unsigned DIV_INIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_step,
  output logic             tick,
  output logic             div_clk,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, PAUSE = 2'b11} st_t;
  st_t st;
  logic [DIV_W-1:0] div_reg, div_cnt;
  logic [CNT_W-1:0] limit_reg, cnt_nxt;
  logic adv, hit, lim, clr;
  assign state = st;
  assign busy = st == RUN || st == STEP;
  // gated by rst so every output reads 0 while reset is held
  assign cfg_ready = rst && (st == IDLE || st == PAUSE);
  assign clr = st == IDLE && (cmd_step || cmd_start);
  assign cnt_nxt = tick_count + CNT_W'(1);
  assign hit = adv && div_cnt == div_reg;
  assign lim = hit && limit_reg != '0 && cnt_nxt == limit_reg;
`ifdef DIVCTRL_PRESCALE_EN
  logic [3:0] pre;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre <= '0;
    else pre <= clr ? '0 : busy ? (pre == 4'd9 ? '0 : pre + 4'd1) : pre;
  end
  assign adv = busy && pre == 4'd9;
`else
  assign adv = busy;
`endif
  // the divider advances on the current state; commands only steer the next state,
  // so a stop coinciding with a tick still lets that tick issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      div_cnt <= '0;
      tick_count <= '0;
      tick <= 1'b0;
      div_clk <= 1'b0;
      done <= 1'b0;
      div_reg <= DIV_W'(DIV_INIT);
      limit_reg <= '0;
    end else begin
      tick <= hit;
      done <= lim;
      div_clk <= hit ? ~div_clk : div_clk;
      if (cfg_valid && cfg_ready) begin
        div_reg <= cfg_div;
        limit_reg <= cfg_limit;
      end
      div_cnt <= (clr || hit) ? '0 : adv ? div_cnt + DIV_W'(1) : div_cnt;
      tick_count <= clr ? '0 : hit ? cnt_nxt : tick_count;
      case (st)
        IDLE:    st <= cmd_step ? STEP : cmd_start ? RUN : IDLE;
        RUN:     st <= lim ? IDLE : cmd_stop ? PAUSE : RUN;
        STEP:    st <= lim ? IDLE : (hit || cmd_stop) ? PAUSE : STEP;
        default: st <= cmd_stop ? IDLE : cmd_step ? STEP : cmd_start ? RUN : PAUSE;
      endcase
    end
  end
endmodule
